// File: rtl/pi_lock_sequencer.sv
// pi_lock_sequencer: drives one picore regulator through offset ramp, settle, and PI lock.
// It watches the loop rail flags in LOCK, counts faults, and can relock automatically.
module pi_lock_sequencer #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16,
  parameter int FCNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 relock_en,
  input  logic [WIDTH-1:0]     ramp_target,
  input  logic [WIDTH-1:0]     ramp_step,
  input  logic [CNT_WIDTH-1:0] ramp_interval,
  input  logic [CNT_WIDTH-1:0] settle_cycles,
  input  logic                 overflow,
  input  logic                 underflow,
  output logic                 sclr,
  output logic                 enable,
  output logic                 set_output_offset,
  output logic                 set_output_clk,
  output logic [WIDTH-1:0]     output_offset,
  output logic [2:0]           state,
  output logic                 locked,
  output logic [FCNT_W-1:0]    fault_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RAMP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LOCK   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  state_e               state_q,  state_d;
  logic [WIDTH-1:0]     cur_q,    cur_d;
  logic [WIDTH-1:0]     off_q,    off_d;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0]     tgt_q,    tgt_d;
  logic [WIDTH-1:0]     step_q,   step_d;
  logic [CNT_WIDTH-1:0] ivl_q,    ivl_d;
  logic [CNT_WIDTH-1:0] settle_q, settle_d;
  logic                 sclr_q,   sclr_d;
  logic                 en_q,     en_d;
  logic                 seto_q,   seto_d;
  logic                 sclk_q,   sclk_d;
  logic                 lock_q,   lock_d;
  logic [FCNT_W-1:0]    fcnt_q,   fcnt_d;

  logic [CNT_WIDTH-1:0] ivl_in;
  logic                 ramp_up;
  logic [WIDTH-1:0]     ramp_dist;
  logic [WIDTH-1:0]     ramp_next;
  logic                 do_launch;
  logic                 do_latch;

  // Next ramp value: step toward target, clamping onto it so the value never overshoots or wraps.
  always_comb begin
    ivl_in    = (ramp_interval == '0) ? CNT_WIDTH'(1) : ramp_interval;
    ramp_up   = (cur_q < tgt_q);
    ramp_dist = ramp_up ? (tgt_q - cur_q) : (cur_q - tgt_q);
    if ((step_q == '0) || (ramp_dist <= step_q)) begin
      ramp_next = tgt_q;
    end else if (ramp_up) begin
      ramp_next = cur_q + step_q;
    end else begin
      ramp_next = cur_q - step_q;
    end
  end

  // Next-state and registered-output logic. Stop overrides every other input.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    ivl_d     = ivl_q;
    settle_d  = settle_q;
    sclr_d    = 1'b0;
    en_d      = en_q;
    seto_d    = seto_q;
    sclk_d    = 1'b0;
    lock_d    = lock_q;
    fcnt_d    = fcnt_q;
    do_launch = 1'b0;
    do_latch  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      seto_d  = 1'b0;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            do_launch = 1'b1;
            do_latch  = 1'b1;
          end
        end
        ST_RAMP: begin
          // Write on the last count of each interval, including when already at target.
          if (cnt_q <= CNT_WIDTH'(1)) begin
            cur_d  = ramp_next;
            off_d  = ramp_next;
            sclk_d = 1'b1;
            if (ramp_next == tgt_q) begin
              state_d = ST_SETTLE;
              cnt_d   = settle_q;
            end else begin
              cnt_d = ivl_q;
            end
          end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            seto_d  = 1'b0;
            en_d    = 1'b1;
            lock_d  = 1'b1;
            state_d = ST_LOCK;
          end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end
        end
        ST_LOCK: begin
          // Either rail flag (or both together) is a single fault.
          if (overflow || underflow) begin
            en_d    = 1'b0;
            lock_d  = 1'b0;
            state_d = ST_FAULT;
            if (fcnt_q != '1) begin
              fcnt_d = fcnt_q + FCNT_W'(1);
            end
          end
        end
        ST_FAULT: begin
          // An explicit start reloads parameters; autorelock reuses the held ones.
          if (start) begin
            do_launch = 1'b1;
            do_latch  = 1'b1;
          end else if (relock_en) begin
            do_launch = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (do_latch) begin
      tgt_d    = ramp_target;
      step_d   = ramp_step;
      ivl_d    = ivl_in;
      settle_d = settle_cycles;
    end
    if (do_launch) begin
      sclr_d  = 1'b1;
      seto_d  = 1'b1;
      state_d = ST_RAMP;
      cnt_d   = do_latch ? ivl_in : ivl_q;
    end
  end

  // State and output registers; async reset returns everything, including cur, to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      tgt_q    <= '0;
      step_q   <= '0;
      ivl_q    <= '0;
      settle_q <= '0;
      sclr_q   <= 1'b0;
      en_q     <= 1'b0;
      seto_q   <= 1'b0;
      sclk_q   <= 1'b0;
      lock_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      ivl_q    <= ivl_d;
      settle_q <= settle_d;
      sclr_q   <= sclr_d;
      en_q     <= en_d;
      seto_q   <= seto_d;
      sclk_q   <= sclk_d;
      lock_q   <= lock_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign sclr              = sclr_q;
  assign enable            = en_q;
  assign set_output_offset = seto_q;
  assign set_output_clk    = sclk_q;
  assign output_offset     = off_q;
  assign state             = state_q;
  assign locked            = lock_q;
  assign fault_count       = fcnt_q;

endmodule
